cic_rate_ctrl: RTL and testbench



---
 rtl/cic_ctrl_pkg.sv | 12 +
 rtl/cic_rate_ctrl_sat_counter.sv | 19 +
 rtl/cic_rate_ctrl.sv | 139 +++++++++++++
 tb/tb_cic_rate_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cic_ctrl_pkg.sv
// Shared types and constants for the cic_d rate-change sequencer.
package cic_ctrl_pkg;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    RUN    = 2'd1,
    APPLY  = 2'd2
  } cic_rate_state_t;

  localparam int unsigned STAT_DW = 16;

endpackage

// File: rtl/cic_rate_ctrl_sat_counter.sv
// Increment-enable counter that stops at all-ones; used for the optional statistics.
module cic_sat_counter
  import cic_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  output logic [STAT_DW-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + STAT_DW'(1);
    end
  end

endmodule

// File: rtl/cic_rate_ctrl.sv
// Rate-change sequencer for cic_d: range-checks rate requests, strobes them to the
// decimator and masks its output until the comb transient has flushed.
// Optional statistics counters are built when CIC_RATE_CTRL_STATS_EN is defined.
module cic_rate_ctrl
  import cic_ctrl_pkg::*;
#(
  parameter int unsigned RATE_DW        = 32,
  parameter int unsigned OUT_DW         = 32,
  parameter int unsigned CIC_R          = 10,
  parameter int unsigned CIC_N          = 7,
  parameter int unsigned SETTLE_SAMPLES = CIC_N
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [RATE_DW-1:0] s_axis_req_tdata,
  input  logic               s_axis_req_tvalid,
  output logic               s_axis_req_tready,
  output logic [RATE_DW-1:0] cic_rate_tdata,
  output logic               cic_rate_tvalid,
  input  logic [OUT_DW-1:0]  cic_out_tdata,
  input  logic               cic_out_tvalid,
  output logic [OUT_DW-1:0]  m_axis_out_tdata,
  output logic               m_axis_out_tvalid,
  output logic [RATE_DW-1:0] cur_rate,
  output logic               settling,
  output logic               rate_err
`ifdef CIC_RATE_CTRL_STATS_EN
  ,
  output logic [STAT_DW-1:0] stat_changes,
  output logic [STAT_DW-1:0] stat_rejected,
  output logic [STAT_DW-1:0] stat_dropped
`endif
);

  localparam int unsigned CNT_W = $clog2(SETTLE_SAMPLES + 1);

  if (SETTLE_SAMPLES < 1) begin : g_settle_chk
    $error("cic_rate_ctrl: SETTLE_SAMPLES must be at least 1");
  end

  cic_rate_state_t  state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic             handshake, in_range, accept, reject, fwd;

  // tready is high exactly in RUN, so a handshake implies the RUN state.
  assign handshake = s_axis_req_tvalid & s_axis_req_tready;
  assign in_range  = (s_axis_req_tdata != '0) && (s_axis_req_tdata <= RATE_DW'(CIC_R));
  assign accept    = handshake & in_range;
  assign reject    = handshake & ~in_range;
  assign fwd       = (state == RUN) & cic_out_tvalid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SETTLE;
      count <= CNT_W'(SETTLE_SAMPLES);
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      SETTLE: begin
        if (cic_out_tvalid) begin
          count_next = count - CNT_W'(1);
          if (count == CNT_W'(1)) state_next = RUN;
        end
      end
      RUN: begin
        if (accept) state_next = APPLY;
      end
      APPLY: begin
        state_next = SETTLE;
        count_next = CNT_W'(SETTLE_SAMPLES);
      end
      default: begin
        state_next = SETTLE;
        count_next = CNT_W'(SETTLE_SAMPLES);
      end
    endcase
  end

  // Registered outputs; the rate strobe fires in the APPLY cycle that follows acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_axis_req_tready <= 1'b0;
      settling          <= 1'b1;
      cic_rate_tdata    <= RATE_DW'(CIC_R);
      cic_rate_tvalid   <= 1'b0;
      cur_rate          <= RATE_DW'(CIC_R);
      rate_err          <= 1'b0;
      m_axis_out_tdata  <= '0;
      m_axis_out_tvalid <= 1'b0;
    end else begin
      s_axis_req_tready <= (state_next == RUN);
      settling          <= (state_next != RUN);
      cic_rate_tvalid   <= accept;
      if (accept) begin
        cic_rate_tdata <= s_axis_req_tdata;
        cur_rate       <= s_axis_req_tdata;
        rate_err       <= 1'b0;
      end else if (reject) begin
        rate_err <= 1'b1;
      end
      m_axis_out_tvalid <= fwd;
      if (fwd) m_axis_out_tdata <= cic_out_tdata;
    end
  end

`ifdef CIC_RATE_CTRL_STATS_EN
  logic drop;
  assign drop = cic_out_tvalid & (state != RUN);

  cic_sat_counter u_stat_changes (
    .clk   (clk),
    .reset (reset),
    .inc   (accept),
    .count (stat_changes)
  );

  cic_sat_counter u_stat_rejected (
    .clk   (clk),
    .reset (reset),
    .inc   (reject),
    .count (stat_rejected)
  );

  cic_sat_counter u_stat_dropped (
    .clk   (clk),
    .reset (reset),
    .inc   (drop),
    .count (stat_dropped)
  );
`endif

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Directed bench for cic_rate_ctrl (CIC_R=10, SETTLE_SAMPLES=3); stats checks need CIC_RATE_CTRL_STATS_EN.
module tb_cic_rate_ctrl;
  import cic_ctrl_pkg::*;

  localparam int unsigned RATE_DW = 32;
  localparam int unsigned OUT_DW  = 32;

  logic               clk = 1'b0;
  logic               reset;
  logic [RATE_DW-1:0] req_tdata;
  logic               req_tvalid;
  logic               req_tready;
  logic [RATE_DW-1:0] rate_tdata;
  logic               rate_tvalid;
  logic [OUT_DW-1:0]  cout_tdata;
  logic               cout_tvalid;
  logic [OUT_DW-1:0]  out_tdata;
  logic               out_tvalid;
  logic [RATE_DW-1:0] cur_rate;
  logic               settling;
  logic               rate_err;
`ifdef CIC_RATE_CTRL_STATS_EN
  logic [STAT_DW-1:0] stat_changes, stat_rejected, stat_dropped;
`endif

  cic_rate_ctrl #(
    .RATE_DW        (RATE_DW),
    .OUT_DW         (OUT_DW),
    .CIC_R          (10),
    .CIC_N          (3),
    .SETTLE_SAMPLES (3)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .s_axis_req_tdata  (req_tdata),
    .s_axis_req_tvalid (req_tvalid),
    .s_axis_req_tready (req_tready),
    .cic_rate_tdata    (rate_tdata),
    .cic_rate_tvalid   (rate_tvalid),
    .cic_out_tdata     (cout_tdata),
    .cic_out_tvalid    (cout_tvalid),
    .m_axis_out_tdata  (out_tdata),
    .m_axis_out_tvalid (out_tvalid),
    .cur_rate          (cur_rate),
    .settling          (settling),
    .rate_err          (rate_err)
`ifdef CIC_RATE_CTRL_STATS_EN
    ,
    .stat_changes      (stat_changes),
    .stat_rejected     (stat_rejected),
    .stat_dropped      (stat_dropped)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [31:0] rd;
    logic        ov;
    logic [31:0] od;
    logic        rdy;
    logic        set;
    logic        err;
    logic        mv;
    logic [31:0] md;
    logic        rtv;
    logic [31:0] rtd;
    logic [31:0] cur;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   split;

  function automatic vec_t mk(input logic rv, input logic [31:0] rd, input logic ov,
                              input logic [31:0] od, input logic rdy, input logic set,
                              input logic err, input logic mv, input logic [31:0] md,
                              input logic rtv, input logic [31:0] rtd, input logic [31:0] cur);
    vec_t v;
    v.rv = rv; v.rd = rd; v.ov = ov; v.od = od;
    v.rdy = rdy; v.set = set; v.err = err; v.mv = mv; v.md = md;
    v.rtv = rtv; v.rtd = rtd; v.cur = cur;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic rdy, input logic set, input logic err,
                           input logic mv, input logic [31:0] md, input logic rtv,
                           input logic [31:0] rtd, input logic [31:0] cur);
    check({tag, ".tready"},   32'(req_tready),  32'(rdy));
    check({tag, ".settling"}, 32'(settling),    32'(set));
    check({tag, ".rate_err"}, 32'(rate_err),    32'(err));
    check({tag, ".m_tvalid"}, 32'(out_tvalid),  32'(mv));
    check({tag, ".m_tdata"},  out_tdata,        md);
    check({tag, ".r_tvalid"}, 32'(rate_tvalid), 32'(rtv));
    check({tag, ".r_tdata"},  rate_tdata,       rtd);
    check({tag, ".cur_rate"}, cur_rate,         cur);
  endtask

  task automatic cyc(input logic rv, input logic [31:0] rd, input logic ov, input logic [31:0] od);
    req_tvalid  = rv;
    req_tdata   = rd;
    cout_tvalid = ov;
    cout_tdata  = od;
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input int first, input int last);
    for (int i = first; i < last; i++) begin
      cyc(vecs[i].rv, vecs[i].rd, vecs[i].ov, vecs[i].od);
      check_out($sformatf("v%0d", i), vecs[i].rdy, vecs[i].set, vecs[i].err, vecs[i].mv,
                vecs[i].md, vecs[i].rtv, vecs[i].rtd, vecs[i].cur);
    end
  endtask

  task automatic check_stats(input string tag, input int ch, input int rj, input int dr);
`ifdef CIC_RATE_CTRL_STATS_EN
    check({tag, ".stat_changes"},  32'(stat_changes),  32'(ch));
    check({tag, ".stat_rejected"}, 32'(stat_rejected), 32'(rj));
    check({tag, ".stat_dropped"},  32'(stat_dropped),  32'(dr));
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            rv rd            ov od   rdy set err mv md  rtv rtd cur
    // Scenario 1: three samples masked after reset, fourth forwarded
    vecs.push_back(mk(0, 0,            1, 1,   0, 1, 0, 0, 0,   0, 10, 10));
    vecs.push_back(mk(0, 0,            1, 2,   0, 1, 0, 0, 0,   0, 10, 10));
    vecs.push_back(mk(0, 0,            1, 3,   1, 0, 0, 0, 0,   0, 10, 10));
    vecs.push_back(mk(0, 0,            1, 4,   1, 0, 0, 1, 4,   0, 10, 10));
    vecs.push_back(mk(0, 0,            0, 0,   1, 0, 0, 0, 4,   0, 10, 10));
    // Scenario 2: rate 5 accepted while a sample is forwarded in the same cycle
    vecs.push_back(mk(1, 5,            1, 100, 0, 1, 0, 1, 100, 1, 5,  5));
    vecs.push_back(mk(0, 0,            0, 0,   0, 1, 0, 0, 100, 0, 5,  5));
    vecs.push_back(mk(0, 0,            1, 11,  0, 1, 0, 0, 100, 0, 5,  5));
    vecs.push_back(mk(0, 0,            1, 12,  0, 1, 0, 0, 100, 0, 5,  5));
    vecs.push_back(mk(0, 0,            1, 13,  1, 0, 0, 0, 100, 0, 5,  5));
    vecs.push_back(mk(0, 0,            1, 14,  1, 0, 0, 1, 14,  0, 5,  5));
    // Scenario 3: 0 and 11 rejected, then 10 accepted
    vecs.push_back(mk(1, 0,            0, 0,   1, 0, 1, 0, 14,  0, 5,  5));
    vecs.push_back(mk(1, 11,           0, 0,   1, 0, 1, 0, 14,  0, 5,  5));
    vecs.push_back(mk(0, 0,            0, 0,   1, 0, 1, 0, 14,  0, 5,  5));
    vecs.push_back(mk(1, 10,           0, 0,   0, 1, 0, 0, 14,  1, 10, 10));
    vecs.push_back(mk(0, 0,            0, 0,   0, 1, 0, 0, 14,  0, 10, 10));
    vecs.push_back(mk(0, 0,            1, 21,  0, 1, 0, 0, 14,  0, 10, 10));
    vecs.push_back(mk(0, 0,            1, 22,  0, 1, 0, 0, 14,  0, 10, 10));
    vecs.push_back(mk(0, 0,            1, 23,  1, 0, 0, 0, 14,  0, 10, 10));
    vecs.push_back(mk(0, 0,            1, 24,  1, 0, 0, 1, 24,  0, 10, 10));
    vecs.push_back(mk(0, 0,            0, 0,   1, 0, 0, 0, 24,  0, 10, 10));
    split = vecs.size();
    // Scenario 4: back-to-back 5 then 7; sample in APPLY is dropped
    vecs.push_back(mk(1, 5,            0, 0,   0, 1, 0, 0, 24,  1, 5,  5));
    vecs.push_back(mk(1, 7,            1, 55,  0, 1, 0, 0, 24,  0, 5,  5));
    vecs.push_back(mk(1, 7,            1, 60,  0, 1, 0, 0, 24,  0, 5,  5));
    vecs.push_back(mk(1, 7,            1, 61,  0, 1, 0, 0, 24,  0, 5,  5));
    vecs.push_back(mk(1, 7,            1, 62,  1, 0, 0, 0, 24,  0, 5,  5));
    vecs.push_back(mk(1, 7,            0, 0,   0, 1, 0, 0, 24,  1, 7,  7));
    vecs.push_back(mk(0, 0,            0, 0,   0, 1, 0, 0, 24,  0, 7,  7));
    vecs.push_back(mk(0, 0,            1, 70,  0, 1, 0, 0, 24,  0, 7,  7));
    vecs.push_back(mk(0, 0,            1, 71,  0, 1, 0, 0, 24,  0, 7,  7));
    vecs.push_back(mk(0, 0,            1, 72,  1, 0, 0, 0, 24,  0, 7,  7));
    // Full-width range check: high bit set must be rejected
    vecs.push_back(mk(1, 32'h80000005, 0, 0,   1, 0, 1, 0, 24,  0, 7,  7));
    // Accept 3, then park in SETTLE with count 1 and a pending request
    vecs.push_back(mk(1, 3,            0, 0,   0, 1, 0, 0, 24,  1, 3,  3));
    vecs.push_back(mk(0, 0,            0, 0,   0, 1, 0, 0, 24,  0, 3,  3));
    vecs.push_back(mk(0, 0,            1, 80,  0, 1, 0, 0, 24,  0, 3,  3));
    vecs.push_back(mk(0, 0,            1, 81,  0, 1, 0, 0, 24,  0, 3,  3));
    vecs.push_back(mk(1, 4,            0, 0,   0, 1, 0, 0, 24,  0, 3,  3));

    reset       = 1'b1;
    req_tvalid  = 1'b0;
    req_tdata   = '0;
    cout_tvalid = 1'b0;
    cout_tdata  = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_out("reset", 0, 1, 0, 0, 0, 0, 10, 10);
    check_stats("reset", 0, 0, 0);
    reset = 1'b0;

    run_table(0, split);
    check_stats("after_s3", 2, 2, 9);
    run_table(split, vecs.size());
    check_stats("before_rst", 5, 3, 18);

    // Reset mid-SETTLE with request 4 still pending
    reset = 1'b1;
    cyc(1, 4, 0, 0);
    check_out("mid_rst", 0, 1, 0, 0, 0, 0, 10, 10);
    check_stats("mid_rst", 0, 0, 0);
    reset = 1'b0;
    // Full count of three must be restored; request is not replayed
    cyc(0, 0, 1, 90);
    check_out("post_rst0", 0, 1, 0, 0, 0, 0, 10, 10);
    cyc(0, 0, 1, 91);
    check_out("post_rst1", 0, 1, 0, 0, 0, 0, 10, 10);
    cyc(0, 0, 1, 92);
    check_out("post_rst2", 1, 0, 0, 0, 0, 0, 10, 10);
    cyc(0, 0, 1, 93);
    check_out("post_rst3", 1, 0, 0, 1, 93, 0, 10, 10);
    cyc(0, 0, 0, 0);
    check_out("post_rst4", 1, 0, 0, 0, 93, 0, 10, 10);
    check_stats("end", 0, 0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
